// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//
// Purpose:
//   Interrupt controller. It synchronises and edge-detects the external
//   interrupt lines and latches each rising edge as a pending bit. Pending bits
//   are masked and gated by the global enable cr[3]. The lowest-index eligible
//   source is presented to the sequencer with an irq/irq_ack handshake. On
//   acknowledge it switches to the supervisor bank and remembers the previous
//   bank. On reti it restores that bank.
//   All state updates on the falling edge of clk.
//
// Ports:
//   clk        in   system clock (state updates on falling edge)
//   reset      in   asynchronous active-low reset
//   irq_lines  in   raw asynchronous interrupt sources, rising-edge triggered
//   cr         in   control register value, cr[3] = global irq enable
//   mask_we    in   mask register write strobe
//   mask_in    in   new mask value (1 = source enabled)
//   mask_out   out  current mask register
//   pending    out  latched pending bits
//   irq        out  interrupt request to sequencer
//   irq_vec    out  index of requested source, stable while irq=1
//   irq_ack    in   sequencer accepts the request
//   reti       in   return-from-interrupt strobe
//   bank       out  0 = user, 1 = supervisor
// -----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2,
    localparam int VEC_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic [7:0]         cr,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_in,
    output logic [NUM_IRQ-1:0] mask_out,
    output logic [NUM_IRQ-1:0] pending,
    output logic               irq,
    output logic [VEC_W-1:0]   irq_vec,
    input  logic               irq_ack,
    input  logic               reti,
    output logic               bank
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t                                r_state;
    state_t                                w_state_nxt;
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0]   r_sync;
    logic [NUM_IRQ-1:0]                    r_dly;
    logic [NUM_IRQ-1:0]                    r_pending;
    logic [NUM_IRQ-1:0]                    r_mask;
    logic [VEC_W-1:0]                      r_vec;
    logic                                  r_bank;
    logic                                  r_saved_bank;

    logic [NUM_IRQ-1:0]                    w_rise;
    logic [NUM_IRQ-1:0]                    w_elig;
    logic [NUM_IRQ-1:0]                    w_clr;
    logic [VEC_W-1:0]                      w_pri_vec;
    logic [VEC_W-1:0]                      w_vec_nxt;
    logic                                  w_bank_nxt;
    logic                                  w_saved_nxt;

    // Rising edge seen at the end of the synchroniser chain; the delay flop
    // makes a held-high level produce a single event.
    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_dly;
    assign w_elig = r_pending & r_mask & {NUM_IRQ{cr[3]}};

    // Lowest index wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        w_pri_vec = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_pri_vec = VEC_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_clr       = '0;
        w_bank_nxt  = r_bank;
        w_saved_nxt = r_saved_bank;
        case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = S_REQ;
                    w_vec_nxt   = w_pri_vec;
                end
            end
            S_REQ: begin
                // Ack has priority over withdrawal and over a coincident reti.
                if (irq_ack) begin
                    w_state_nxt   = S_SERVICE;
                    w_clr[r_vec]  = 1'b1;
                    w_saved_nxt   = r_bank;
                    w_bank_nxt    = 1'b1;
                end else if (!w_elig[r_vec]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (reti) begin
                    w_state_nxt = S_IDLE;
                    w_bank_nxt  = r_saved_bank;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_sync       <= '0;
            r_dly        <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_vec        <= '0;
            r_bank       <= 1'b1;
            r_saved_bank <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_sync       <= {r_sync[SYNC_STAGES-2:0], irq_lines};
            r_dly        <= r_sync[SYNC_STAGES-1];
            // Set after clear: a new edge on the acked bit is never lost.
            r_pending    <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_in;
            end
            r_vec        <= w_vec_nxt;
            r_bank       <= w_bank_nxt;
            r_saved_bank <= w_saved_nxt;
        end
    end

    assign mask_out = r_mask;
    assign pending  = r_pending;
    assign irq      = (r_state == S_REQ);
    assign irq_vec  = r_vec;
    assign bank     = r_bank;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] irq_lines;
    logic [7:0] cr;
    logic       mask_we;
    logic [7:0] mask_in;
    logic [7:0] mask_out;
    logic [7:0] pending;
    logic       irq;
    logic [2:0] irq_vec;
    logic       irq_ack;
    logic       reti;
    logic       bank;

    int n_cmp = 0;
    int n_err = 0;

    irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_lines (irq_lines),
        .cr        (cr),
        .mask_we   (mask_we),
        .mask_in   (mask_in),
        .mask_out  (mask_out),
        .pending   (pending),
        .irq       (irq),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .reti      (reti),
        .bank      (bank)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Advance n falling edges; return 1 time unit after the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b exp 0", irq); end
        n_cmp++; if (irq_vec !== 3'd0) begin n_err++; $display("FAIL rst_vec got %0d exp 0", irq_vec); end
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL rst_pend got %h exp 00", pending); end
        n_cmp++; if (mask_out !== 8'h00) begin n_err++; $display("FAIL rst_mask got %h exp 00", mask_out); end
        n_cmp++; if (bank !== 1'b1) begin n_err++; $display("FAIL rst_bank got %b exp 1", bank); end
    endtask

    task automatic test_single();
        mask_we = 1'b1; mask_in = 8'hFF; cr = 8'h08;
        step(1);
        mask_we = 1'b0;
        n_cmp++; if (mask_out !== 8'hFF) begin n_err++; $display("FAIL single_mask got %h exp ff", mask_out); end
        irq_lines = 8'h20;
        step(2);
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL single_pend2 got %h exp 00", pending); end
        step(1);
        n_cmp++; if (pending !== 8'h20) begin n_err++; $display("FAIL single_pend3 got %h exp 20", pending); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL single_irq3 got %b exp 0", irq); end
        step(1);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL single_irq4 got %b exp 1", irq); end
        n_cmp++; if (irq_vec !== 3'd5) begin n_err++; $display("FAIL single_vec got %0d exp 5", irq_vec); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL single_ack_irq got %b exp 0", irq); end
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL single_ack_pend got %h exp 00", pending); end
        // Line still held high: no second event.
        step(3);
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL single_level got %h exp 00", pending); end
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        irq_lines = 8'h00;
        step(3);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL single_end_irq got %b exp 0", irq); end
    endtask

    task automatic test_two_sources();
        irq_lines = 8'h44;
        step(3);
        n_cmp++; if (pending !== 8'h44) begin n_err++; $display("FAIL two_pend got %h exp 44", pending); end
        step(1);
        n_cmp++; if (irq !== 1'b1 || irq_vec !== 3'd2) begin n_err++; $display("FAIL two_req1 got irq=%b vec=%0d exp irq=1 vec=2", irq, irq_vec); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        n_cmp++; if (pending !== 8'h40) begin n_err++; $display("FAIL two_ack_pend got %h exp 40", pending); end
        n_cmp++; if (bank !== 1'b1) begin n_err++; $display("FAIL two_svc_bank got %b exp 1", bank); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL two_svc_irq got %b exp 0", irq); end
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        n_cmp++; if (irq !== 1'b0 || bank !== 1'b1) begin n_err++; $display("FAIL two_reti got irq=%b bank=%b exp irq=0 bank=1", irq, bank); end
        step(1);
        n_cmp++; if (irq !== 1'b1 || irq_vec !== 3'd6) begin n_err++; $display("FAIL two_req2 got irq=%b vec=%0d exp irq=1 vec=6", irq, irq_vec); end
        // Higher-priority source arrives during REQ: vector must not change.
        irq_lines = 8'h46;
        step(3);
        n_cmp++; if (pending !== 8'h42) begin n_err++; $display("FAIL two_hp_pend got %h exp 42", pending); end
        n_cmp++; if (irq !== 1'b1 || irq_vec !== 3'd6) begin n_err++; $display("FAIL two_hp_hold got irq=%b vec=%0d exp irq=1 vec=6", irq, irq_vec); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        n_cmp++; if (pending !== 8'h02) begin n_err++; $display("FAIL two_ack2_pend got %h exp 02", pending); end
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        step(1);
        n_cmp++; if (irq !== 1'b1 || irq_vec !== 3'd1) begin n_err++; $display("FAIL two_req3 got irq=%b vec=%0d exp irq=1 vec=1", irq, irq_vec); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        irq_lines = 8'h00;
        step(3);
        n_cmp++; if (pending !== 8'h00 || irq !== 1'b0) begin n_err++; $display("FAIL two_end got pend=%h irq=%b exp pend=00 irq=0", pending, irq); end
    endtask

    task automatic test_mask_drop();
        irq_lines = 8'h08;
        step(4);
        n_cmp++; if (irq !== 1'b1 || irq_vec !== 3'd3) begin n_err++; $display("FAIL mask_req got irq=%b vec=%0d exp irq=1 vec=3", irq, irq_vec); end
        mask_we = 1'b1; mask_in = 8'hF7;
        step(1);
        mask_we = 1'b0;
        n_cmp++; if (mask_out !== 8'hF7) begin n_err++; $display("FAIL mask_wr got %h exp f7", mask_out); end
        step(1);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_drop got irq=%b exp 0", irq); end
        n_cmp++; if (pending !== 8'h08) begin n_err++; $display("FAIL mask_keep_pend got %h exp 08", pending); end
        mask_we = 1'b1; mask_in = 8'hFF;
        step(1);
        mask_we = 1'b0;
        step(1);
        n_cmp++; if (irq !== 1'b1 || irq_vec !== 3'd3) begin n_err++; $display("FAIL mask_rereq got irq=%b vec=%0d exp irq=1 vec=3", irq, irq_vec); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        irq_lines = 8'h00;
        step(3);
    endtask

    task automatic test_cr_gate();
        cr = 8'h00;
        irq_lines = 8'h01;
        step(3);
        n_cmp++; if (pending !== 8'h01) begin n_err++; $display("FAIL cr_pend got %h exp 01", pending); end
        step(2);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL cr_off_irq got %b exp 0", irq); end
        cr = 8'h08;
        step(2);
        n_cmp++; if (irq !== 1'b1 || irq_vec !== 3'd0) begin n_err++; $display("FAIL cr_on_irq got irq=%b vec=%0d exp irq=1 vec=0", irq, irq_vec); end
        cr = 8'h00;
        step(1);
        n_cmp++; if (irq !== 1'b0 || pending !== 8'h01) begin n_err++; $display("FAIL cr_withdraw got irq=%b pend=%h exp irq=0 pend=01", irq, pending); end
        cr = 8'h08;
        step(1);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        irq_lines = 8'h00;
        step(3);
        n_cmp++; if (pending !== 8'h00 || irq !== 1'b0) begin n_err++; $display("FAIL cr_end got pend=%h irq=%b exp pend=00 irq=0", pending, irq); end
    endtask

    task automatic test_back_to_back();
        irq_lines = 8'h10;
        step(4);
        n_cmp++; if (irq !== 1'b1 || irq_vec !== 3'd4) begin n_err++; $display("FAIL b2b_req got irq=%b vec=%0d exp irq=1 vec=4", irq, irq_vec); end
        // Re-raise line 4 so its new rise lands on the ack edge.
        irq_lines = 8'h00;
        step(1);
        irq_lines = 8'h10;
        step(2);
        irq_ack = 1'b1;
        step(1);
        n_cmp++; if (pending !== 8'h10) begin n_err++; $display("FAIL b2b_ack_pend got %h exp 10", pending); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL b2b_svc_irq got %b exp 0", irq); end
        // Ack held in SERVICE is ignored.
        step(1);
        irq_ack = 1'b0;
        n_cmp++; if (irq !== 1'b0 || pending !== 8'h10) begin n_err++; $display("FAIL b2b_ack_svc got irq=%b pend=%h exp irq=0 pend=10", irq, pending); end
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        step(1);
        n_cmp++; if (irq !== 1'b1 || irq_vec !== 3'd4) begin n_err++; $display("FAIL b2b_rereq got irq=%b vec=%0d exp irq=1 vec=4", irq, irq_vec); end
        // reti alone in REQ is ignored.
        reti = 1'b1;
        step(1);
        n_cmp++; if (irq !== 1'b1 || bank !== 1'b1) begin n_err++; $display("FAIL b2b_reti_req got irq=%b bank=%b exp irq=1 bank=1", irq, bank); end
        // ack + reti in REQ: ack wins.
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        reti = 1'b0;
        n_cmp++; if (irq !== 1'b0 || pending !== 8'h00) begin n_err++; $display("FAIL b2b_ack_reti got irq=%b pend=%h exp irq=0 pend=00", irq, pending); end
        step(1);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL b2b_still_svc got irq=%b exp 0", irq); end
        reti = 1'b1;
        step(1);
        // Stray strobes in IDLE with nothing pending.
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        reti = 1'b0;
        n_cmp++; if (irq !== 1'b0 || bank !== 1'b1 || pending !== 8'h00) begin n_err++; $display("FAIL b2b_idle_strobe got irq=%b bank=%b pend=%h exp 0/1/00", irq, bank, pending); end
        irq_lines = 8'h00;
        step(3);
    endtask

    task automatic test_reset_mid();
        irq_lines = 8'hC0;
        step(4);
        n_cmp++; if (irq !== 1'b1 || irq_vec !== 3'd6) begin n_err++; $display("FAIL rmid_req got irq=%b vec=%0d exp irq=1 vec=6", irq, irq_vec); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        n_cmp++; if (pending !== 8'h80 || bank !== 1'b1) begin n_err++; $display("FAIL rmid_svc got pend=%h bank=%b exp pend=80 bank=1", pending, bank); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL rmid_pend got %h exp 00", pending); end
        n_cmp++; if (mask_out !== 8'h00) begin n_err++; $display("FAIL rmid_mask got %h exp 00", mask_out); end
        n_cmp++; if (irq !== 1'b0 || irq_vec !== 3'd0 || bank !== 1'b1) begin n_err++; $display("FAIL rmid_ctl got irq=%b vec=%0d bank=%b exp 0/0/1", irq, irq_vec, bank); end
        @(posedge clk);
        reset = 1'b1;
        // Lines still high: cleared synchronisers see a fresh edge; mask=0
        // must not block latching but must block the request.
        step(3);
        n_cmp++; if (pending !== 8'hC0) begin n_err++; $display("FAIL rmid_relatch got %h exp c0", pending); end
        step(1);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rmid_masked_irq got %b exp 0", irq); end
    endtask

    initial begin
        reset = 1'b0;
        irq_lines = 8'h00;
        cr = 8'h00;
        mask_we = 1'b0;
        mask_in = 8'h00;
        irq_ack = 1'b0;
        reti = 1'b0;
        #12;
        test_reset();
        @(posedge clk);
        reset = 1'b1;
        test_single();
        test_two_sources();
        test_mask_drop();
        test_cr_gate();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
